// File: rtl/shifter_pkg.sv
// Shared types for pipelined_shifter and its barrel stages.
// Optional carry-out feature is selected by PIPE_SHIFTER_CARRY_EN.
package shifter_pkg;

  localparam int MAX_W       = 64;
  localparam int MAX_SHAMT_W = 6;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  // Sized for the widest supported operand; modules use the low DATA_W bits.
  typedef struct packed {
    logic [MAX_W-1:0]       data;
    logic [MAX_SHAMT_W-1:0] shamt;
    shift_op_e              op;
    logic                   carry;
  } stage_pl_t;

  function automatic int levels_per_stage(
    input int shamt_w,
    input int stages
  );
    return (shamt_w + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// Combinational barrel levels LO..HI of one pipeline stage.
// Carry tracking is compiled in only with PIPE_SHIFTER_CARRY_EN.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LO     = 0,
  parameter int HI     = 0
) (
  input  stage_pl_t i_pl,
  output stage_pl_t o_pl
);

  localparam int SHAMT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] w_d;
  logic              w_c;

  always_comb begin
    w_d = i_pl.data[DATA_W-1:0];
    w_c = i_pl.carry;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (k >= LO && k <= HI && i_pl.shamt[k]) begin
        // Last bit out of this level equals last bit out overall.
        unique case (i_pl.op)
          OP_SLL: begin
`ifdef PIPE_SHIFTER_CARRY_EN
            w_c = w_d[DATA_W-(1<<k)];
`endif
            w_d = w_d << (1 << k);
          end
          OP_SRL: begin
`ifdef PIPE_SHIFTER_CARRY_EN
            w_c = w_d[(1<<k)-1];
`endif
            w_d = w_d >> (1 << k);
          end
          OP_SRA: begin
`ifdef PIPE_SHIFTER_CARRY_EN
            w_c = w_d[(1<<k)-1];
`endif
            w_d = $signed(w_d) >>> (1 << k);
          end
          OP_ROR: begin
`ifdef PIPE_SHIFTER_CARRY_EN
            w_c = w_d[(1<<k)-1];
`endif
            w_d = (w_d >> (1 << k))
                | (w_d << (DATA_W - (1 << k)));
          end
          default: w_d = w_d;
        endcase
      end
    end
    o_pl                    = i_pl;
    o_pl.data               = '0;
    o_pl.data[DATA_W-1:0]   = w_d;
    o_pl.carry              = w_c;
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready flow.
// Define PIPE_SHIFTER_CARRY_EN to add the out_carry port.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter  int DATA_W      = 32,
  parameter  int PIPE_STAGES = 2,
  localparam int SHAMT_W     = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef PIPE_SHIFTER_CARRY_EN
  output logic               out_carry,
`endif
  output logic [DATA_W-1:0]  out_data
);

  localparam int LPS  = levels_per_stage(SHAMT_W, PIPE_STAGES);
  localparam int LAST = PIPE_STAGES - 1;

  stage_pl_t              w_in_pl;
  stage_pl_t              w_nx [PIPE_STAGES];
  stage_pl_t              r_pl [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] r_v;
  logic [PIPE_STAGES-1:0] w_adv;
  logic                   r_en;

  always_comb begin
    w_in_pl                     = '0;
    w_in_pl.data[DATA_W-1:0]    = in_data;
    w_in_pl.shamt[SHAMT_W-1:0]  = in_shamt;
    w_in_pl.op                  = shift_op_e'(in_op);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_en <= 1'b0;
    else        r_en <= 1'b1;
  end

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    localparam int LO = i * LPS;
    localparam int HI = (i + 1) * LPS - 1;

    stage_pl_t w_src;
    logic      w_src_v;

    // A stage moves if any register at or after it is empty.
    assign w_adv[i] = out_ready || !(&r_v[LAST:i]);

    if (i == 0) begin : g_head
      assign w_src   = w_in_pl;
      assign w_src_v = in_valid && r_en;
    end else begin : g_body
      assign w_src   = r_pl[i-1];
      assign w_src_v = r_v[i-1];
    end

    shift_stage #(
      .DATA_W(DATA_W),
      .LO    (LO),
      .HI    (HI)
    ) u_stage (
      .i_pl(w_src),
      .o_pl(w_nx[i])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v[i]  <= 1'b0;
        r_pl[i] <= '0;
      end else if (w_adv[i]) begin
        r_v[i] <= w_src_v;
        if (w_src_v) r_pl[i] <= w_nx[i];
      end
    end
  end

  assign in_ready  = r_en && w_adv[0];
  assign out_valid = r_v[LAST];
  assign out_data  = r_pl[LAST].data[DATA_W-1:0];
`ifdef PIPE_SHIFTER_CARRY_EN
  assign out_carry = r_pl[LAST].carry;
`endif

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench: four shifters (PIPE_STAGES 2,1,3,5) share one
// stimulus stream; each has its own expected-result queue.
module tb_pipelined_shifter;

  typedef struct {
    logic [31:0] d;
    logic        c;
    int          t;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_ready;

  logic        ir_a   [4];
  logic        ov_a   [4];
  logic [31:0] od_a   [4];
  logic        ordy_a [4];
`ifdef PIPE_SHIFTER_CARRY_EN
  logic        oc_a   [4];
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int pend  [4];
  bit bp_phase = 0;
  bit bp_watch = 0;
  bit saw_drop = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: shifts on double-width values; returns {carry, result}.
  function automatic logic [32:0] ref_model(
    input logic [31:0] d,
    input int          sh,
    input logic [1:0]  op
  );
    logic [63:0] x;
    logic [31:0] r;
    logic        c;
    case (op)
      2'd0: begin
        x = {32'b0, d} << sh;
        r = x[31:0];
        c = x[32];
      end
      2'd1: begin
        x = {d, 32'b0} >> sh;
        r = x[63:32];
        c = x[31];
      end
      2'd2: begin
        x = 64'($signed({d, 32'b0}) >>> sh);
        r = x[63:32];
        c = x[31];
      end
      default: begin
        x = {d, d} >> sh;
        r = x[31:0];
        c = r[31];
      end
    endcase
    if (sh == 0) c = 1'b0;
    return {c, r};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int P = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 5;
    exp_t        q[$];
    logic        hold_v = 1'b0;
    logic [31:0] hold_d = '0;

    assign ordy_a[g] = (g == 0) ? out_ready : 1'b1;

    pipelined_shifter #(
      .DATA_W     (32),
      .PIPE_STAGES(P)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (ir_a[g]),
      .in_data  (in_data),
      .in_shamt (in_shamt),
      .in_op    (in_op),
      .out_valid(ov_a[g]),
      .out_ready(ordy_a[g]),
`ifdef PIPE_SHIFTER_CARRY_EN
      .out_carry(oc_a[g]),
`endif
      .out_data (od_a[g])
    );

    always @(negedge clk) begin
      exp_t        e;
      logic [32:0] m;
      int          lat;
      if (!rst_n) begin
        q.delete();
        pend[g] = 0;
        hold_v  = 1'b0;
      end else begin
        if (hold_v) begin
          n_cmp++;
          if (!ov_a[g] || od_a[g] !== hold_d) begin
            n_bad++;
            $display("FAIL hold inst=%0d got v=%0b d=%h want v=1 d=%h",
                     g, ov_a[g], od_a[g], hold_d);
          end
        end
        hold_v = ov_a[g] && !ordy_a[g];
        hold_d = od_a[g];
        if (ov_a[g] && ordy_a[g]) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out inst=%0d got=%h want=none",
                     g, od_a[g]);
          end else begin
            e = q.pop_front();
            pend[g]--;
            lat = cyc - e.t;
            n_cmp++;
            if (od_a[g] !== e.d) begin
              n_bad++;
              $display("FAIL data inst=%0d got=%h want=%h",
                       g, od_a[g], e.d);
            end
            n_cmp++;
            if ((g != 0 || !bp_phase) ? (lat != P) : (lat < P)) begin
              n_bad++;
              $display("FAIL latency inst=%0d got=%0d want=%0d",
                       g, lat, P);
            end
`ifdef PIPE_SHIFTER_CARRY_EN
            n_cmp++;
            if (oc_a[g] !== e.c) begin
              n_bad++;
              $display("FAIL carry inst=%0d got=%0b want=%0b",
                       g, oc_a[g], e.c);
            end
`endif
          end
        end
        if (in_valid && ir_a[g]) begin
          m   = ref_model(in_data, int'(in_shamt), in_op);
          e.d = m[31:0];
          e.c = m[32];
          e.t = cyc;
          q.push_back(e);
          pend[g]++;
        end
      end
    end
  end

  always @(negedge clk)
    if (bp_watch && rst_n && !ir_a[0]) saw_drop = 1;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Enter and leave one time unit after a rising edge.
  task automatic send(input logic [31:0] d, input logic [4:0] sh,
                      input logic [1:0] op);
    int w;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_op    = op;
    w = 0;
    @(negedge clk);
    while (!ir_a[0] && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout got=stalled want=accept");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((pend[0] + pend[1] + pend[2] + pend[3]) != 0 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    for (int g = 0; g < 4; g++)
      check($sformatf("drain_pending%0d", g), pend[g], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

  initial begin
    bit done;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(ov_a[0]), 0);
    check("rst_out_data", od_a[0], 0);
    check("rst_in_ready", 32'(ir_a[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("in_ready_before_edge", 32'(ir_a[0]), 0);
    @(posedge clk);
    #1;
    check("in_ready_after_edge", 32'(ir_a[0]), 1);

    for (int op = 0; op < 4; op++) send(32'h8000_00F1, 5'd4, 2'(op));
    for (int op = 0; op < 4; op++) begin
      send(32'h8000_0001, 5'd0, 2'(op));
      send(32'h8000_0001, 5'd31, 2'(op));
    end
    send(32'hF0F0_1234, 5'd31, 2'd2);
    drain();

    bp_phase = 1;
    bp_watch = 1;
    fork
      for (int i = 0; i < 8; i++)
        send(32'h1111_1111 * (i + 1), 5'(i * 3), 2'(i));
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    bp_watch = 0;
    drain();
    check("bp_in_ready_dropped", 32'(saw_drop), 1);
    bp_phase = 0;

    send(32'hDEAD_BEEF, 5'd7, 2'd3);
    send(32'hCAFE_F00D, 5'd9, 2'd2);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(ov_a[0]), 0);
    check("async_rst_in_ready", 32'(ir_a[0]), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_idle_valid", 32'(ov_a[0]), 0);
    check("post_rst_idle_valid_p5", 32'(ov_a[3]), 0);

`ifdef PIPE_SHIFTER_CARRY_EN
    send(32'h0000_000B, 5'd1, 2'd1);
    send(32'h0000_000B, 5'd0, 2'd0);
    drain();
`endif

    bp_phase = 1;
    done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++)
          send($urandom, 5'($urandom_range(0, 31)),
               2'($urandom_range(0, 3)));
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    bp_phase = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
